ap_bitserial_tag_seq: RTL
=========================

Name: ap_bitserial_tag_seq

Overview:
- Bit-serial arithmetic sequencer sitting directly upstream of the result-cell array.
- For every bit column it compares the stored A/B operand bits and a per-row carry against a pass key.
- It then drives tag, Mask, Pass and ABS_opt into the result array, so each row's result bit is written in place.
- It holds the per-row carry register and reports the final carry/borrow per row.

Parameters:
- DATA_WIDTH, 4, bits per word (number of columns).
- DATA_DEPTH, 4, number of rows/words.
- OP_ADD, 2'd1, opcode for R = A + B.
- OP_SUB, 2'd2, opcode for R = A - B (A + ~B + 1).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  opcode, sampled with start.
- Q_A  in  DATA_WIDTH*DATA_DEPTH  A array contents; row i bit j at index i*DATA_WIDTH+j.
- Q_B  in  DATA_WIDTH*DATA_DEPTH  B array contents, same layout.
- tag  out  DATA_DEPTH  row-select vector to the result array.
- Mask  out  DATA_WIDTH  one-hot column enable; zero outside write cycles.
- Pass  out  3  pass index 1..3 in write cycles, 0 otherwise.
- ABS_opt  out  1  held 0 by this block.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- carry_out  out  DATA_DEPTH  final per-row carry (ADD) or no-borrow (SUB); valid from done until the next accepted start.

Behaviour:
- Reset values: tag=0, Mask=0, Pass=0, ABS_opt=0, busy=0, done=0, carry_out=0; FSM goes to IDLE, bit counter 0, pass counter 1.
- States:
  - IDLE: start=1 with op in {OP_ADD, OP_SUB} -> CMP, busy=1, bit=0, pass=1, carry reg = (op==OP_SUB) ? all-ones : all-zero. An invalid op is ignored and the block stays IDLE.
  - CMP (1 cycle): per row i, a=Q_A[i][bit], b=Q_B[i][bit] (inverted for SUB), c=carry[i], s=a^b^c. Register next tag:
    - pass1: s!=a and c==0.
    - pass2: s!=a and c==1.
    - pass3: s==a.
    - Mask=0, Pass=0 during CMP. Next state WR.
  - WR (1 cycle): drive registered tag, Mask=1<<bit, Pass=pass.
    - The result array writes ~A for passes 1/2 and A for pass 3, so R[bit]=s in every row.
    - pass<3: pass++ -> CMP.
    - pass==3: carry[i] <= maj(a,b,c) for all rows, then pass=1. If bit==DATA_WIDTH-1 go to DONE, else bit++ -> CMP.
  - DONE (1 cycle): done=1, busy=0, carry_out=carry, tag/Mask/Pass=0 -> IDLE.
- Latency: start accepted at edge 0; done high during cycle 6*DATA_WIDTH+1; next start is accepted in the cycle after done.
- Operand sampling: Q_A/Q_B are sampled live in every CMP cycle, so they must stay stable while busy. The block does not modify A/B.
- start while busy or in DONE: ignored, no queueing.
- rst mid-operation: immediate return to reset values. The result array keeps any partially written columns, and carry_out is cleared.
- Pass tags are disjoint across passes 1/2/3 and together cover every row, so each row is written exactly once per bit.
- Outputs are registered; no combinational path from Q_A/Q_B to tag.

Decomposition:
- Shared package: opcodes OP_ADD/OP_SUB, the pass encodings 1..3, FSM state encodings (IDLE, CMP, WR, DONE), and the Pass/Mask field widths, so the result array and this block agree.
- One natural sub-module, ap_row_key_match: combinational per-row match of (a,b,c) against the pass index, producing the next-tag bit and the majority carry. It is instantiated DATA_DEPTH times.

Test Plan (DATA_WIDTH=4, DATA_DEPTH=4):
- ADD, rows A={3,7,15,0}, B={5,9,1,0}: write stream applied to a result-array model gives R={8,0,0,0}, carry_out=4'b0110, done at cycle 25.
- SUB, rows A={9,2,0,15}, B={4,5,0,15}: R={5,13,0,0}, carry_out (no-borrow)=4'b1101.
- Per-cycle check in any op: Mask one-hot only when Pass!=0. Each row is tagged in exactly one of passes 1..3 per bit. Write cycle count equals 12.
- start pulsed at cycles 3 and 10 during busy: no effect, done still occurs exactly once at cycle 25.
- rst asserted at cycle 9 of an ADD: next cycle all outputs are 0 and state is IDLE. A new start at cycle 12 completes correctly 25 cycles later.
- start with op=2'd3 or op=0: busy stays 0, no writes issued.

Source files
------------

// File: rtl/ap_bitserial_tag_seq_pkg.sv
// ap_bitserial_tag_seq_pkg: opcodes, pass encodings, FSM states and field widths shared with the result array
package ap_bitserial_tag_seq_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;
  localparam int PASS_W = 3;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [PASS_W-1:0] PASS_NONE = 3'd0;
  localparam logic [PASS_W-1:0] PASS1 = 3'd1;
  localparam logic [PASS_W-1:0] PASS2 = 3'd2;
  localparam logic [PASS_W-1:0] PASS3 = 3'd3;
  typedef enum logic [1:0] {IDLE, CMP, WR, DONE} state_t;
endpackage

// File: rtl/ap_bitserial_tag_seq_if.sv
// ap_bitserial_tag_seq_if: request, operand and result-array drive signals of the tag sequencer
interface ap_bitserial_tag_seq_if
  import ap_bitserial_tag_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_WIDTH,
  parameter int DATA_DEPTH = DEF_DEPTH
);
  logic start;
  logic [1:0] op;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] Q_A;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] Q_B;
  logic [DATA_DEPTH-1:0] tag;
  logic [DATA_WIDTH-1:0] Mask;
  logic [PASS_W-1:0] Pass;
  logic ABS_opt;
  logic busy;
  logic done;
  logic [DATA_DEPTH-1:0] carry_out;
  modport master (output start, op, Q_A, Q_B, input tag, Mask, Pass, ABS_opt, busy, done, carry_out);
  modport slave (input start, op, Q_A, Q_B, output tag, Mask, Pass, ABS_opt, busy, done, carry_out);
endinterface

// File: rtl/ap_row_key_match.sv
// ap_row_key_match: per-row match of (a,b,c) against the pass key, plus majority carry
module ap_row_key_match
  import ap_bitserial_tag_seq_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic [PASS_W-1:0] pass,
  output logic match,
  output logic maj
);
  logic s;
  always_comb begin
    s = a ^ b ^ c;
    match = pass == PASS1 ? (s != a) && !c :
            pass == PASS2 ? (s != a) && c :
            pass == PASS3 ? s == a : 1'b0;
    maj = (a & b) | (a & c) | (b & c);
  end
endmodule

// File: rtl/ap_bitserial_tag_seq.sv
// ap_bitserial_tag_seq: bit-serial add/sub sequencer driving tag/Mask/Pass into the result array
module ap_bitserial_tag_seq
  import ap_bitserial_tag_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_WIDTH,
  parameter int DATA_DEPTH = DEF_DEPTH
)(
  input logic clk,
  input logic rst,
  ap_bitserial_tag_seq_if.slave bus
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t state;
  logic [BW-1:0] bit_idx;
  logic [PASS_W-1:0] pass;
  logic sub;
  logic [DATA_DEPTH-1:0] carry, match, maj;
  for (genvar i = 0; i < DATA_DEPTH; i++) begin : g_row
    logic [DATA_WIDTH-1:0] qa, qb;
    assign qa = bus.Q_A[i*DATA_WIDTH +: DATA_WIDTH];
    assign qb = bus.Q_B[i*DATA_WIDTH +: DATA_WIDTH];
    ap_row_key_match u_match (
      .a(qa[bit_idx]), .b(qb[bit_idx] ^ sub), .c(carry[i]),
      .pass(pass), .match(match[i]), .maj(maj[i])
    );
  end
  assign bus.ABS_opt = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_idx <= '0;
      pass <= PASS1;
      sub <= 1'b0;
      carry <= '0;
      bus.tag <= '0;
      bus.Mask <= '0;
      bus.Pass <= PASS_NONE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.carry_out <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && (bus.op == OP_ADD || bus.op == OP_SUB)) begin
          state <= CMP;
          bus.busy <= 1'b1;
          bit_idx <= '0;
          pass <= PASS1;
          sub <= bus.op == OP_SUB;
          carry <= {DATA_DEPTH{bus.op == OP_SUB}};
        end
        CMP: begin
          bus.tag <= match;
          bus.Mask <= DATA_WIDTH'(1) << bit_idx;
          bus.Pass <= pass;
          state <= WR;
        end
        WR: begin
          bus.tag <= '0;
          bus.Mask <= '0;
          bus.Pass <= PASS_NONE;
          if (pass != PASS3) begin
            pass <= pass + PASS_W'(1);
            state <= CMP;
          end else begin
            // operands are still stable here, so maj reflects this column's a/b/c
            carry <= maj;
            pass <= PASS1;
            if (bit_idx == BW'(DATA_WIDTH - 1)) begin
              state <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.carry_out <= maj;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              state <= CMP;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
